// File: rtl/mealy2.sv
// Mealy detector for the serial pattern 1100 (MSB first), overlapping search.
// op is combinational from the state register and ip; state is exported for debug.
module mealy2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       ip,
  output logic       op,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S0;
    end else begin
      case (cur)
        S0:      cur <= ip ? S1 : S0;
        S1:      cur <= ip ? S2 : S0;
        S2:      cur <= ip ? S2 : S3;
        // a completed 1100 leaves no usable prefix
        S3:      cur <= ip ? S1 : S0;
        default: cur <= S0;
      endcase
    end
  end

  assign op    = (cur == S3) && !ip;
  assign state = cur;

endmodule

// File: tb/tb_mealy2.sv
// Randomized + directed bench for mealy2, checked against a bit-history model.
module tb_mealy2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ip = 1'b0;
  logic       op;
  logic [1:0] state;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // model: bits seen since the last reset (most recent at the back)
  bit hist[$];
  bit known = 1'b0;
  int pat[4] = '{1, 1, 0, 0};

  mealy2 dut (
    .clk   (clk),
    .reset (reset),
    .ip    (ip),
    .op    (op),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // length of the longest history suffix that is a proper prefix of 1100
  function automatic int model_state();
    for (int k = 3; k >= 1; k--) begin
      if (hist.size() >= k) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (int'(hist[hist.size() - k + i]) != pat[i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic bit model_op(input bit b);
    int n = hist.size();
    if (n < 3) return 1'b0;
    return hist[n-3] == 1'b1 && hist[n-2] == 1'b1 && hist[n-1] == 1'b0 && b == 1'b0;
  endfunction

  // drive one bit on the falling edge, check op before and state after the rising edge
  task automatic step(input bit b, input bit rst, input string tag, output bit seen_op);
    @(negedge clk);
    ip = b;
    reset = rst;
    #4;
    seen_op = op;
    if (known) check({tag, ".op"}, {1'b0, op}, {1'b0, model_op(b)});
    @(posedge clk);
    #1;
    if (rst) begin
      hist.delete();
      known = 1'b1;
    end else if (known) begin
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    if (known) check({tag, ".state"}, state, 2'(model_state()));
  endtask

  task automatic run_seq(input bit bits[$], input string tag, output int pulses, output int last_pulse);
    bit o;
    pulses = 0;
    last_pulse = -1;
    foreach (bits[i]) begin
      step(bits[i], 1'b0, tag, o);
      if (o) begin
        pulses++;
        last_pulse = i + 1;
      end
    end
  endtask

  initial begin
    bit o;
    int pulses, lastp;
    bit stream[$];

    // reset with ip=0
    step(1'b0, 1'b1, "reset", o);
    check("reset.state", state, 2'b00);
    check("reset.op", {1'b0, op}, 2'b00);

    // basic detect
    run_seq('{1, 1, 0, 0}, "basic", pulses, lastp);
    check("basic.pulses", 2'(pulses), 2'd1);
    check("basic.pos", 2'(lastp), 2'(4));
    check("basic.final", state, 2'b00);

    // near miss
    run_seq('{1, 1, 0, 1}, "near", pulses, lastp);
    check("near.pulses", 2'(pulses), 2'd0);
    check("near.final", state, 2'b01);

    // run of ones
    step(1'b0, 1'b1, "rst2", o);
    run_seq('{1, 1, 1, 1, 0, 0}, "ones", pulses, lastp);
    check("ones.pulses", 2'(pulses), 2'd1);
    vectors++;
    if (lastp != 6) begin
      miscompares++;
      $display("FAIL ones.pos: got %0d, expected 6", lastp);
    end

    // full stream after reset
    step(1'b0, 1'b1, "rst3", o);
    stream = '{0,1,1,0,1,0,1,0,0,1,0,0,1,1,0,0,1,0,0,0,1,0,1};
    run_seq(stream, "stream", pulses, lastp);
    check("stream.pulses", 2'(pulses), 2'd1);
    vectors++;
    if (lastp != 16) begin
      miscompares++;
      $display("FAIL stream.pos: got %0d, expected 16", lastp);
    end
    check("stream.final", state, 2'b01);

    // reset mid-pattern
    step(1'b0, 1'b1, "rst4", o);
    run_seq('{1, 1, 0}, "mid", pulses, lastp);
    check("mid.pre", state, 2'b11);
    step(1'b0, 1'b1, "mid.rst", o);
    check("mid.rststate", state, 2'b00);
    step(1'b0, 1'b0, "mid.after", o);
    check("mid.op", {1'b0, o}, 2'b00);
    check("mid.final", state, 2'b00);

    // random stream, biased toward ones, with occasional resets
    for (int i = 0; i < 2000; i++) begin
      bit b = ($urandom_range(99) < 60);
      bit r = ($urandom_range(99) < 3);
      step(b, r, "rand", o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
